// File: rtl/md_pad_scanner_pkg.sv
// Shared constants and types for the Mega Drive pad scanner.
// Button/pin indices, phase count, FSM states and the frame record.
package md_pad_pkg;

   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;
   localparam int unsigned BTN_A     = 4;
   localparam int unsigned BTN_B     = 5;
   localparam int unsigned BTN_C     = 6;
   localparam int unsigned BTN_START = 7;
   localparam int unsigned BTN_X     = 8;
   localparam int unsigned BTN_Y     = 9;
   localparam int unsigned BTN_Z     = 10;
   localparam int unsigned BTN_MODE  = 11;

   localparam int unsigned PIN_D0 = 0;
   localparam int unsigned PIN_D1 = 1;
   localparam int unsigned PIN_D2 = 2;
   localparam int unsigned PIN_D3 = 3;
   localparam int unsigned PIN_TL = 4;
   localparam int unsigned PIN_TR = 5;

   localparam int unsigned NUM_PHASES = 8;
   localparam int unsigned PHASE_W    = $clog2(NUM_PHASES);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } state_e;

   typedef struct packed {
      logic [11:0] buttons;
      logic        present;
      logic        six;
   } frame_t;

   localparam frame_t FRAME_RESET = '{buttons: 12'hFFF, present: 1'b0, six: 1'b0};

endpackage

// File: rtl/md_pad_scanner_if.sv
// Connector-side pins and the published button bundle of the pad scanner.
interface md_pad_scanner_if;

   logic [5:0]  md_pins;
   logic        md_th;
   logic [11:0] buttons;
   logic        pad_present;
   logic        is_six;
   logic        frame_strobe;

   modport master (
      input  md_pins,
      output md_th,
      output buttons,
      output pad_present,
      output is_six,
      output frame_strobe
   );

   modport slave (
      output md_pins,
      input  md_th,
      input  buttons,
      input  pad_present,
      input  is_six,
      input  frame_strobe
   );

endinterface

// File: rtl/md_pin_sync.sv
// Two-flop synchronizer for asynchronous pad pins; resets to all ones (released).
module md_pin_sync #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/md_pad_scanner.sv
// Mega Drive 3/6-button pad sequencer: walks TH through eight phases, captures
// the pins into a shadow frame and publishes it atomically once per scan.
module md_pad_scanner
   import md_pad_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = 500,
   parameter int unsigned IDLE_CYCLES  = 100000
) (
   input  logic           system_clock,
   input  logic           reset_n,
   md_pad_scanner_if.master pad
);

   localparam int unsigned CNT_MAX = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0]   IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
   localparam logic [PHASE_W-1:0] LAST_PH    = PHASE_W'(NUM_PHASES - 1);

   logic [5:0] pins_s;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               th_q, th_d;
   logic               strobe_q, strobe_d;
   frame_t             shadow_q, shadow_d;
   frame_t             out_q, out_d;

   md_pin_sync #(.WIDTH(6)) u_pin_sync (
      .clk   (system_clock),
      .rst_n (reset_n),
      .d     (pad.md_pins),
      .q     (pins_s)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      th_d     = th_q;
      strobe_d = 1'b0;
      shadow_d = shadow_q;
      out_d    = out_q;

      case (state_q)
         IDLE: begin
            th_d = 1'b1;
            if (cnt_q == IDLE_LAST) begin
               state_d = SCAN;
               cnt_d   = '0;
               phase_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         SCAN: begin
            if (cnt_q == PHASE_LAST) begin
               cnt_d = '0;
               case (phase_q)
                  PHASE_W'(0): begin
                     shadow_d.buttons[BTN_UP]    = pins_s[PIN_D0];
                     shadow_d.buttons[BTN_DOWN]  = pins_s[PIN_D1];
                     shadow_d.buttons[BTN_LEFT]  = pins_s[PIN_D2];
                     shadow_d.buttons[BTN_RIGHT] = pins_s[PIN_D3];
                     shadow_d.buttons[BTN_B]     = pins_s[PIN_TL];
                     shadow_d.buttons[BTN_C]     = pins_s[PIN_TR];
                  end
                  PHASE_W'(1): begin
                     shadow_d.buttons[BTN_A]     = pins_s[PIN_TL];
                     shadow_d.buttons[BTN_START] = pins_s[PIN_TR];
                     shadow_d.present = !pins_s[PIN_D2] && !pins_s[PIN_D3];
                  end
                  PHASE_W'(5): begin
                     shadow_d.six = (pins_s[PIN_D3:PIN_D0] == 4'b0000);
                  end
                  PHASE_W'(6): begin
                     shadow_d.buttons[BTN_Z]    = pins_s[PIN_D0];
                     shadow_d.buttons[BTN_Y]    = pins_s[PIN_D1];
                     shadow_d.buttons[BTN_X]    = pins_s[PIN_D2];
                     shadow_d.buttons[BTN_MODE] = pins_s[PIN_D3];
                  end
                  default: ;
               endcase
               if (phase_q == LAST_PH) begin
                  state_d = COMMIT;
                  th_d    = 1'b1;
               end else begin
                  phase_d = phase_q + PHASE_W'(1);
                  // next phase is odd (TH low) exactly when the current one is even
                  th_d    = phase_q[0];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         COMMIT: begin
            th_d     = 1'b1;
            strobe_d = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
            if (!shadow_q.present) begin
               out_d = FRAME_RESET;
            end else if (!shadow_q.six) begin
               out_d                   = shadow_q;
               out_d.buttons[BTN_X]    = 1'b1;
               out_d.buttons[BTN_Y]    = 1'b1;
               out_d.buttons[BTN_Z]    = 1'b1;
               out_d.buttons[BTN_MODE] = 1'b1;
               out_d.six               = 1'b0;
            end else begin
               out_d = shadow_q;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            th_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge system_clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         phase_q  <= '0;
         th_q     <= 1'b1;
         strobe_q <= 1'b0;
         shadow_q <= '1;
         out_q    <= FRAME_RESET;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         th_q     <= th_d;
         strobe_q <= strobe_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
      end
   end

   assign pad.md_th        = th_q;
   assign pad.buttons      = out_q.buttons;
   assign pad.pad_present  = out_q.present;
   assign pad.is_six       = out_q.six;
   assign pad.frame_strobe = strobe_q;

endmodule

// File: doc/md_pad_scanner.md
Name: md_pad_scanner

Overview:
- Sequences a Mega Drive 3/6-button pad.
- Toggles the pad's TH select line through the 8-phase six-button protocol and samples the pad's six data pins in each phase.
- Publishes a debounced-by-frame, active-low 12-button bundle plus pad-type flags.
- Sits between the MD connector pins and the PC Engine pad-emulation logic, which consumes the bundle.

Parameters:
- PHASE_CYCLES, 500: system_clock cycles per TH phase (10 us @ 50 MHz); must be >= 4.
- IDLE_CYCLES, 100000: cycles TH is held high between scans (2 ms); must be >= 1.5 ms worth so the pad's internal phase counter resets; must be >= 1.

Ports:
- system_clock  input  1  Sole clock.
- reset_n  input  1  Synchronous, active-low reset.
- md_pins  input  6  Raw pad pins D0..D5 (D0 up, D1 down, D2 left, D3 right, D4 TL, D5 TR); asynchronous to system_clock.
- md_th  output  1  TH select line to pad.
- buttons  output  12  Active-low bundle (0 = pressed). Index: 0 up, 1 down, 2 left, 3 right, 4 a, 5 b, 6 c, 7 start, 8 x, 9 y, 10 z, 11 mode.
- pad_present  output  1  Pad detected in the last completed frame.
- is_six  output  1  Last completed frame identified a six-button pad.
- frame_strobe  output  1  One-cycle pulse when the outputs update.

Behaviour:
- Synchronous active-low reset, sampled on posedge system_clock. Reset is fixed as synchronous and active-low.
- Reset values:
  - md_th = 1, buttons = 12'hFFF, pad_present = 0, is_six = 0, frame_strobe = 0.
  - FSM = IDLE, counter = 0, phase = 0; shadow capture registers all 1.
- Input sync: md_pins pass through a 2-flop synchronizer (reset to all 1). All sampling uses the synchronized value.
- FSM states: IDLE -> SCAN -> COMMIT -> IDLE.
  - IDLE: md_th = 1. Counter runs 0..IDLE_CYCLES-1, then goes to SCAN with phase = 0 and counter = 0.
  - SCAN: md_th = 1 for even phases, 0 for odd phases (registered, changes on the same edge as the phase). Counter runs 0..PHASE_CYCLES-1. On counter == PHASE_CYCLES-1, sample the synced pins into shadow registers per the phase table, then advance the phase. After phase 7 completes, go to COMMIT.
  - COMMIT: one cycle. Copy shadow to outputs, pulse frame_strobe = 1, reset counter, go to IDLE. md_th = 1.
- Phase sample table (TH shown in brackets):
  - Phase 0 [H]: up = D0, down = D1, left = D2, right = D3, b = D4, c = D5.
  - Phase 1 [L]: a = D4, start = D5; present_sh = (D2 == 0 && D3 == 0).
  - Phases 2 [H], 3 [L], 4 [H]: no capture.
  - Phase 5 [L]: six_sh = (D0..D3 all 0).
  - Phase 6 [H]: z = D0, y = D1, x = D2, mode = D3.
  - Phase 7 [L]: no capture.
- COMMIT rules:
  - If !present_sh: buttons = 12'hFFF, pad_present = 0, is_six = 0.
  - Else if !six_sh: bits 11:8 forced to 1, is_six = 0.
  - Else: full bundle, is_six = 1.
- Outputs hold their values between frame_strobe pulses. They never show a partial frame.
- Frame period is exactly IDLE_CYCLES + 8*PHASE_CYCLES + 1 cycles.
- The first frame_strobe after reset release occurs at cycle IDLE_CYCLES + 8*PHASE_CYCLES + 1 (cycle 0 = first cycle with reset_n = 1).
- Counter width is $clog2 of the larger of IDLE_CYCLES and PHASE_CYCLES. Counter compare is exact and never wraps past the terminal value.
- Reset asserted mid-scan: abort immediately, md_th = 1 on the next edge, outputs return to reset values, full IDLE period before the next scan.
- Pad unplugged mid-scan: pins float high via pull-ups, so present_sh = 0 and the frame commits all released.

Decomposition:
- Package md_pad_pkg:
  - Button index constants (BTN_UP..BTN_MODE).
  - Pin index constants (PIN_D0..PIN_TR).
  - NUM_PHASES = 8.
  - FSM state enum (IDLE, SCAN, COMMIT).
- Sub-module md_pin_sync: parameterised-width 2-flop synchronizer with synchronous active-low reset to all 1.

Test Plan (PHASE_CYCLES = 4, IDLE_CYCLES = 16, behavioural six-button pad model driven by md_th):
- Reset release, no buttons pressed -> md_th sequence H×16, then H,L,H,L,H,L,H,L (4 cycles each); frame_strobe at cycle 49; buttons = 12'hFFF, pad_present = 1, is_six = 1.
- Six-button pad with A, Start and Mode held -> buttons = 12'h76F (bits 4, 7, 11 = 0); next strobe exactly 49 cycles later.
- Three-button pad (phase 5 returns U/D/L/R = real directions) with C and Up held -> buttons = 12'hFBE, is_six = 0; X/Y/Z/Mode are 1 even if the model drives 0 there.
- md_pins tied 6'h3F (no pad) -> pad_present = 0, is_six = 0, buttons = 12'hFFF at every strobe.
- Assert reset_n = 0 during phase 3 for 2 cycles -> md_th = 1 and outputs at reset values on the next edge; next strobe 49 cycles after release.
- Change B pin state only during phases 2-4 -> no effect on buttons[5]; a change before phase 0's last cycle is reflected at the same frame's strobe (sampled value includes 2-cycle sync latency).
